pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, the generalised successor of the fixed-format ID/EX latch. It carries an opaque data bundle and a control bundle through DEPTH register stages, with a valid bit per stage. It supports stall (hold), flush (bubble insertion) and an asynchronous active-low reset. A saturating bubble counter feeds the performance/debug path. It is instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 116, width of the datapath bundle (operands, immediates, register indices); never cleared except by reset or when CLR_DATA_ON_FLUSH=1.
CTRL_W, 12, width of the control bundle (regdst, aluop, alusrc, mem2reg, regwr, memwr, ...); forced to CTRL_BUBBLE on a bubble.
DEPTH, 1, number of register stages, 1..4.
CTRL_BUBBLE, 0, control value that encodes a NOP (no reg write, no mem write).
CLR_DATA_ON_FLUSH, 0, 1 = data bundle also zeroed on flush.
FLUSH_ALL, 0, 1 = flush kills every stage; 0 = flush kills only stage 0.
CNT_W, 16, bubble counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active low.
stall_in  in  1  hold all stages this cycle.
flush_in  in  1  insert bubble (kill) this cycle.
valid_in  in  1  upstream holds a real instruction.
data_in  in  DATA_W  datapath bundle from upstream.
ctrl_in  in  CTRL_W  control bundle from upstream.
valid_out  out  1  last stage holds a real instruction.
data_out  out  DATA_W  last-stage data.
ctrl_out  out  CTRL_W  last-stage control; equals CTRL_BUBBLE whenever valid_out=0.
bubble_cnt  out  CNT_W  count of bubbles written into stage 0, saturating.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - all stage valid bits = 0, data = 0, ctrl = CTRL_BUBBLE, bubble_cnt = 0.
  - Outputs reflect this immediately.
  - Reset asserted mid-stall or mid-flush overrides everything.
- Stages S[0..DEPTH-1]: S[0] loads from the inputs; S[i] loads from S[i-1]; outputs come from S[DEPTH-1] with no combinational path from the inputs. Latency is DEPTH cycles when no stalls occur.
- Per rising edge, priority is flush > stall > advance:
  - flush_in=1:
    - S[0] gets valid=0 and ctrl=CTRL_BUBBLE; data is zeroed if CLR_DATA_ON_FLUSH=1, otherwise data_in is loaded.
    - FLUSH_ALL=1: every stage is killed the same way.
    - FLUSH_ALL=0: S[1..] advance normally, even if stall_in=1. Flush wins over stall, giving the load-use bubble pattern.
  - stall_in=1, flush_in=0: all stages hold (valid, data, ctrl unchanged); bubble_cnt unchanged.
  - Otherwise:
    - all stages advance.
    - S[0] loads valid_in and data_in.
    - S[0] ctrl loads ctrl_in if valid_in=1, else CTRL_BUBBLE.
- Invariant: any stage with valid=0 holds ctrl=CTRL_BUBBLE.
- bubble_cnt increments by 1 on each edge where S[0] is written with valid=0, i.e. flush_in=1 or (stall_in=0 and valid_in=0). It holds at 2^CNT_W-1 once reached (no wrap).
- DEPTH=1 with default parameters is cycle-equivalent to the legacy ID/EX latch when stall_in=flush_in=0 and valid_in=1.
- Not reset-sensitive in any other way. X on data_in while valid_in=0 must not reach ctrl_out.

Test Plan:
1. Reset and latency: rst=0 → valid_out=0, ctrl_out=0, data_out=0, bubble_cnt=0. Release rst, DEPTH=2, drive valid_in=1, data_in=0xA5 (lsbs), ctrl_in=0x802 → appears at the outputs exactly 2 edges later.
2. Stall: DEPTH=1, load ctrl=0x803, then stall_in=1 for 3 cycles while ctrl_in changes to 0x001 → ctrl_out stays 0x803 for 3 cycles and bubble_cnt stays constant.
3. Flush beats stall: stall_in=1 and flush_in=1 on the same edge with ctrl_in=0xFFF → valid_out=0, ctrl_out=0x000, bubble_cnt+1. With CLR_DATA_ON_FLUSH=1, data_out=0 as well.
4. FLUSH_ALL: DEPTH=3 with 3 valid entries, flush_in=1 for one edge → FLUSH_ALL=0 gives valid_out sequence 1,1,0; FLUSH_ALL=1 gives 0,0,0.
5. Counter saturation: CNT_W=4, 20 edges with valid_in=0 → bubble_cnt reaches 15 and stays at 15.
6. Async reset mid-stall: assert rst=0 between clock edges while stall_in=1 and valid_out=1 → outputs clear before the next edge. After release, the first edge with valid_in=1 loads normally.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: DEPTH stages of {valid, data, ctrl} with
// stall/flush control and a saturating count of bubbles written into stage 0.
module pipe_stage_reg #(
  parameter int                 DATA_W            = 116,
  parameter int                 CTRL_W            = 12,
  parameter int                 DEPTH             = 1,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE       = '0,
  parameter bit                 CLR_DATA_ON_FLUSH = 1'b0,
  parameter bit                 FLUSH_ALL         = 1'b0,
  parameter int                 CNT_W             = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];

  logic [DEPTH-1:0]  valid_d;
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];

  logic load;
  logic bubble_wr;

  // Flush overrides stall, so a flushed edge always moves the pipe.
  assign load      = flush_in | ~stall_in;
  assign bubble_wr = flush_in | (~stall_in & ~valid_in);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic              src_v;
      logic [DATA_W-1:0] src_d;
      logic [CTRL_W-1:0] src_c;
      logic              kill;
      if (i == 0) begin
        src_v = valid_in;
        src_d = data_in;
        src_c = valid_in ? ctrl_in : CTRL_BUBBLE;
      end else begin
        src_v = valid_q[i-1];
        src_d = data_q[i-1];
        src_c = ctrl_q[i-1];
      end
      kill       = flush_in & ((i == 0) | FLUSH_ALL);
      valid_d[i] = src_v & ~kill;
      ctrl_d[i]  = kill ? CTRL_BUBBLE : src_c;
      data_d[i]  = (kill && CLR_DATA_ON_FLUSH) ? '0 : src_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        ctrl_q[i] <= CTRL_BUBBLE;
      end
    end else if (load) begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        ctrl_q[i] <= ctrl_d[i];
      end
    end
  end

  // Saturates at all-ones so the debug path never sees a wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bubble_cnt <= '0;
    else if (bubble_wr && (bubble_cnt != {CNT_W{1'b1}}))
      bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

  assign valid_out = valid_q[DEPTH-1];
  assign data_out  = data_q[DEPTH-1];
  assign ctrl_out  = ctrl_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: several parameter variants share one stimulus stream;
// directed checks plus a scoreboard on the DEPTH=2 instance.
module tb_pipe_stage_reg;
  localparam int DW = 116;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_in = 1'b0, flush_in = 1'b0, valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] ctrl_in = '0;

  logic          v1, v1c, v2, v3, v3f, vc4;
  logic [DW-1:0] d1, d1c, d2, d3, d3f, dc4;
  logic [CW-1:0] c1, c1c, c2, c3, c3f, cc4;
  logic [15:0]   n1, n1c, n2, n3, n3f;
  logic [3:0]    nc4;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEPTH(1)) u_d1 (.clk(clk), .rst(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in), .valid_out(v1), .data_out(d1), .ctrl_out(c1), .bubble_cnt(n1));
  pipe_stage_reg #(.DEPTH(1), .CLR_DATA_ON_FLUSH(1'b1)) u_d1c (.clk(clk), .rst(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in), .valid_out(v1c), .data_out(d1c), .ctrl_out(c1c), .bubble_cnt(n1c));
  pipe_stage_reg #(.DEPTH(2)) u_d2 (.clk(clk), .rst(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in), .valid_out(v2), .data_out(d2), .ctrl_out(c2), .bubble_cnt(n2));
  pipe_stage_reg #(.DEPTH(3)) u_d3 (.clk(clk), .rst(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in), .valid_out(v3), .data_out(d3), .ctrl_out(c3), .bubble_cnt(n3));
  pipe_stage_reg #(.DEPTH(3), .FLUSH_ALL(1'b1)) u_d3f (.clk(clk), .rst(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in), .valid_out(v3f), .data_out(d3f), .ctrl_out(c3f), .bubble_cnt(n3f));
  pipe_stage_reg #(.DEPTH(1), .CNT_W(4)) u_c4 (.clk(clk), .rst(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in), .valid_out(vc4), .data_out(dc4), .ctrl_out(cc4), .bubble_cnt(nc4));

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  bit sb_on = 1'b0;
  logic [CW+DW-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic s, input logic f);
    valid_in = v; ctrl_in = c; data_in = d; stall_in = s; flush_in = f;
  endtask

  // One clock edge; bubble count and scoreboard are predicted from the driven inputs.
  task automatic step();
    logic [CW+DW-1:0] e;
    bit adv;
    adv = flush_in || !stall_in;
    if (flush_in || (!stall_in && !valid_in)) exp_cnt++;
    if (sb_on && !flush_in && !stall_in && valid_in) sb_q.push_back({ctrl_in, data_in});
    @(posedge clk);
    #1;
    chk("cnt16", 128'(n1), 128'(exp_cnt));
    chk("cnt4_sat", 128'(nc4), 128'((exp_cnt > 15) ? 15 : exp_cnt));
    if (!v2) chk("d2_bubble_ctrl", 128'(c2), 128'(0));
    if (sb_on && adv && v2) begin
      if (sb_q.size() == 0) chk("sb_underflow", 128'(1), 128'(0));
      else begin
        e = sb_q.pop_front();
        chk("sb_ctrl", 128'(c2), 128'(e[CW+DW-1:DW]));
        chk("sb_data", 128'(d2), 128'(e[DW-1:0]));
      end
    end
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", 128'(v2), 128'(0));
    chk("rst_ctrl", 128'(c2), 128'(0));
    chk("rst_data", 128'(d2), 128'(0));
    chk("rst_cnt", 128'(n2), 128'(0));
    #1 rst_n = 1'b1;

    // DEPTH=2 latency
    drive(1'b1, 12'h802, DW'(8'hA5), 1'b0, 1'b0);
    step();
    chk("lat_d2_edge1_valid", 128'(v2), 128'(0));
    chk("lat_d1_edge1_ctrl", 128'(c1), 128'(12'h802));
    drive(1'b0, 12'h000, '0, 1'b0, 1'b0);
    step();
    chk("lat_d2_edge2_valid", 128'(v2), 128'(1));
    chk("lat_d2_edge2_ctrl", 128'(c2), 128'(12'h802));
    chk("lat_d2_edge2_data", 128'(d2), 128'(8'hA5));
    chk("lat_d1_bubble_valid", 128'(v1), 128'(0));

    // stall holds
    drive(1'b1, 12'h803, DW'(8'h11), 1'b0, 1'b0);
    step();
    chk("stall_load", 128'(c1), 128'(12'h803));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 12'h001, DW'(8'h22), 1'b1, 1'b0);
      step();
      chk("stall_ctrl", 128'(c1), 128'(12'h803));
      chk("stall_data", 128'(d1), 128'(8'h11));
      chk("stall_valid", 128'(v1), 128'(1));
    end

    // flush beats stall
    drive(1'b1, 12'hFFF, DW'(8'h77), 1'b1, 1'b1);
    step();
    chk("flush_valid", 128'(v1), 128'(0));
    chk("flush_ctrl", 128'(c1), 128'(0));
    chk("flush_data_kept", 128'(d1), 128'(8'h77));
    chk("flush_clr_valid", 128'(v1c), 128'(0));
    chk("flush_clr_data", 128'(d1c), 128'(0));

    // FLUSH_ALL comparison at DEPTH=3
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, CW'(12'h100 + i), DW'(i), 1'b0, 1'b0);
      step();
    end
    chk("fa_full_valid", 128'(v3), 128'(1));
    chk("fa_full_ctrl", 128'(c3), 128'(12'h101));
    drive(1'b1, 12'h104, DW'(4), 1'b0, 1'b1);
    step();
    chk("fa0_e1_valid", 128'(v3), 128'(1));
    chk("fa0_e1_ctrl", 128'(c3), 128'(12'h102));
    chk("fa1_e1_valid", 128'(v3f), 128'(0));
    chk("fa1_e1_ctrl", 128'(c3f), 128'(0));
    drive(1'b0, 12'h000, '0, 1'b0, 1'b0);
    step();
    chk("fa0_e2_valid", 128'(v3), 128'(1));
    chk("fa0_e2_ctrl", 128'(c3), 128'(12'h103));
    chk("fa1_e2_valid", 128'(v3f), 128'(0));
    step();
    chk("fa0_e3_valid", 128'(v3), 128'(0));
    chk("fa0_e3_ctrl", 128'(c3), 128'(0));
    chk("fa1_e3_valid", 128'(v3f), 128'(0));

    // counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) step();
    chk("sat_final", 128'(nc4), 128'(15));

    // async reset mid-stall
    drive(1'b1, 12'h805, DW'(8'h5A), 1'b0, 1'b0);
    step();
    drive(1'b1, 12'h00F, DW'(8'h0F), 1'b1, 1'b0);
    step();
    chk("pre_rst_valid", 128'(v1), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(v1), 128'(0));
    chk("arst_ctrl", 128'(c1), 128'(0));
    chk("arst_data", 128'(d1), 128'(0));
    chk("arst_cnt", 128'(n1), 128'(0));
    chk("arst_d3_valid", 128'(v3), 128'(0));
    exp_cnt = 0;
    sb_q.delete();
    #1 rst_n = 1'b1;
    sb_on = 1'b1;
    drive(1'b1, 12'h806, DW'(8'h66), 1'b0, 1'b0);
    step();
    chk("post_rst_valid", 128'(v1), 128'(1));
    chk("post_rst_ctrl", 128'(c1), 128'(12'h806));
    chk("post_rst_data", 128'(d1), 128'(8'h66));

    // randomised stream checked by scoreboard on DEPTH=2
    for (int i = 0; i < 60; i++) begin
      logic v, s, f;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 7) == 0);
      drive(v, CW'($urandom), v ? DW'({$urandom, $urandom, $urandom, $urandom}) : '0, s, f);
      step();
    end
    drive(1'b0, 12'h000, '0, 1'b0, 1'b0);
    step();
    step();
    chk("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
